// File: rtl/result_frame_tx.sv
// result_frame_tx: queues ALU results and streams each one
// to a byte-wide UART transmitter as a framed byte sequence.
module result_frame_tx #(
  parameter int          DATA_W      = 16,
  parameter int          DEPTH       = 4,
  parameter int          HEADER_EN   = 1,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter int          MSB_FIRST   = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    ena,
  input  logic                    push_valid,
  input  logic [DATA_W-1:0]       push_data,
  output logic                    push_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int NBYTES = DATA_W / 8;
  localparam int HDR    = (HEADER_EN != 0) ? 1 : 0;
  localparam int NFRAME = NBYTES + HDR;
  localparam int FW     = 8 * NFRAME;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int IW     = $clog2(NFRAME + 1);

  // Encoding 2'd3 is unused and falls back to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [FW-1:0]     r_shift;
  logic [IW-1:0]     r_idx;
  logic [7:0]        r_tx_data;
  logic              r_frame_done;

  logic [DATA_W-1:0] w_head;
  logic [FW-1:0]     w_frame;
  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic              w_adv;
  logic              w_fin;
  logic              w_full;

  // FIFO status is taken from the registered count only, so a pop
  // never opens room for a push in the same cycle.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = push_valid & ~w_full;
  assign w_pop  = (r_state == S_IDLE) & ena & (r_count != '0);
  assign w_head = r_mem[r_rd_ptr];

  assign w_last = (r_idx == IW'(NFRAME - 1));
  assign w_adv  = (r_state == S_WAIT) & ena & ~tx_busy & ~w_last;
  assign w_fin  = (r_state == S_WAIT) & ena & ~tx_busy & w_last;

  // Result storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Lay out the head result as frame bytes, byte 0 in the low lane.
  always_comb begin
    w_frame = '0;
    if (HDR == 1) begin
      w_frame[7:0] = HEADER_BYTE;
    end
    for (int k = 0; k < NBYTES; k++) begin
      if (MSB_FIRST != 0) begin
        w_frame[(k+HDR)*8 +: 8] = w_head[(NBYTES-1-k)*8 +: 8];
      end else begin
        w_frame[(k+HDR)*8 +: 8] = w_head[k*8 +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; ena low pulls every state back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!ena) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            w_state_nxt = S_SEND;
          end
        end
        S_SEND: begin
          if (tx_busy) begin
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!tx_busy) begin
            w_state_nxt = w_last ? S_IDLE : S_SEND;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs; tx_start is simply "in SEND".
  always_comb begin
    tx_start   = (r_state == S_SEND);
    tx_data    = r_tx_data;
    frame_done = r_frame_done;
    push_ready = ~w_full;
    overflow   = push_valid & w_full;
    fifo_count = r_count;
  end

  // Frame shift register, byte index and completion pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_idx        <= '0;
      r_tx_data    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_fin;
      if (w_pop) begin
        r_tx_data <= w_frame[7:0];
        r_shift   <= w_frame >> 8;
        r_idx     <= '0;
      end else if (w_adv) begin
        r_tx_data <= r_shift[7:0];
        r_shift   <= r_shift >> 8;
        r_idx     <= r_idx + IW'(1);
      end else if (!ena) begin
        r_idx     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_result_frame_tx.sv
// tb_result_frame_tx: directed/random bench for result_frame_tx
// with a busy-holding UART model and a byte-stream reference.
module tb_result_frame_tx;

  localparam int BUSY = 10;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ena;

  logic        pv_a;
  logic [15:0] pd_a;
  logic        pr_a;
  logic        ts_a;
  logic [7:0]  td_a;
  logic        tb_a;
  logic [2:0]  fc_a;
  logic        fd_a;
  logic        ov_a;

  logic        pv_b;
  logic [31:0] pd_b;
  logic        pr_b;
  logic        ts_b;
  logic [7:0]  td_b;
  logic        tb_b;
  logic [2:0]  fc_b;
  logic        fd_b;
  logic        ov_b;

  int errors = 0;
  int checks = 0;

  int bc_a = 0;
  int bc_b = 0;
  int nfd_a = 0;
  int nfd_b = 0;
  int nst_a = 0;
  int nst_b = 0;
  logic ts_a_q = 1'b0;
  logic ts_b_q = 1'b0;

  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int pa = 0;
  int pb = 0;

  always #5 clock = ~clock;

  result_frame_tx dut_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .ena        (ena),
    .push_valid (pv_a),
    .push_data  (pd_a),
    .push_ready (pr_a),
    .tx_start   (ts_a),
    .tx_data    (td_a),
    .tx_busy    (tb_a),
    .fifo_count (fc_a),
    .frame_done (fd_a),
    .overflow   (ov_a)
  );

  result_frame_tx #(
    .DATA_W    (32),
    .DEPTH     (4),
    .HEADER_EN (0),
    .MSB_FIRST (1)
  ) dut_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .ena        (ena),
    .push_valid (pv_b),
    .push_data  (pd_b),
    .push_ready (pr_b),
    .tx_start   (ts_b),
    .tx_data    (td_b),
    .tx_busy    (tb_b),
    .fifo_count (fc_b),
    .frame_done (fd_b),
    .overflow   (ov_b)
  );

  assign tb_a = (bc_a != 0);
  assign tb_b = (bc_b != 0);

  // UART model A: accept a byte when idle and start is seen.
  always @(posedge clock) begin
    if (bc_a != 0) bc_a <= bc_a - 1;
    else if (ts_a) begin
      cap_a.push_back(td_a);
      bc_a <= BUSY;
    end
    if (fd_a) nfd_a <= nfd_a + 1;
    if (ts_a && !ts_a_q) nst_a <= nst_a + 1;
    ts_a_q <= ts_a;
  end

  // UART model B.
  always @(posedge clock) begin
    if (bc_b != 0) bc_b <= bc_b - 1;
    else if (ts_b) begin
      cap_b.push_back(td_b);
      bc_b <= BUSY;
    end
    if (fd_b) nfd_b <= nfd_b + 1;
    if (ts_b && !ts_b_q) nst_b <= nst_b + 1;
    ts_b_q <= ts_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected frame: header, then bytes from least significant up.
  task automatic exp_frame_a(input logic [15:0] v);
    exp_a.push_back(8'hA5);
    for (int k = 0; k < 2; k++) exp_a.push_back(8'(v >> (8 * k)));
  endtask

  // Expected frame: no header, most significant byte first.
  task automatic exp_frame_b(input logic [31:0] v);
    for (int k = 3; k >= 0; k--) exp_b.push_back(8'(v >> (8 * k)));
  endtask

  task automatic cmp(input string tag);
    chk({tag, " len_a"}, 32'(cap_a.size()), 32'(exp_a.size()));
    while (pa < exp_a.size() && pa < cap_a.size()) begin
      chk({tag, " byte_a"}, 32'(cap_a[pa]), 32'(exp_a[pa]));
      pa++;
    end
    chk({tag, " len_b"}, 32'(cap_b.size()), 32'(exp_b.size()));
    while (pb < exp_b.size() && pb < cap_b.size()) begin
      chk({tag, " byte_b"}, 32'(cap_b[pb]), 32'(exp_b[pb]));
      pb++;
    end
  endtask

  task automatic wait_fd(input int ta, input int tbb, input string tag);
    int n;
    n = 0;
    while ((nfd_a < ta || nfd_b < tbb) && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 3000), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    logic [15:0] v1;
    logic [15:0] v2;
    logic [31:0] w;
    int base;
    int fdb;
    int n;

    reset_n = 1'b0;
    ena     = 1'b0;
    pv_a    = 1'b0;
    pd_a    = '0;
    pv_b    = 1'b0;
    pd_b    = '0;
    #2;
    chk("rst ts_a", 32'(ts_a), 32'd0);
    chk("rst fc_a", 32'(fc_a), 32'd0);
    chk("rst pr_a", 32'(pr_a), 32'd1);
    chk("rst td_a", 32'(td_a), 32'd0);
    chk("rst fd_a", 32'(fd_a), 32'd0);
    chk("rst ov_a", 32'(ov_a), 32'd0);
    chk("rst ts_b", 32'(ts_b), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // single frame on both instances, with latency check
    ena  = 1'b1;
    pv_a = 1'b1;
    pd_a = 16'h1234;
    pv_b = 1'b1;
    pd_b = 32'hDEADBEEF;
    exp_frame_a(16'h1234);
    exp_frame_b(32'hDEADBEEF);
    tick();
    pv_a = 1'b0;
    pv_b = 1'b0;
    chk("lat0 ts_a", 32'(ts_a), 32'd0);
    chk("lat0 fc_a", 32'(fc_a), 32'd1);
    chk("lat0 ts_b", 32'(ts_b), 32'd0);
    tick();
    chk("lat1 ts_a", 32'(ts_a), 32'd1);
    chk("lat1 td_a", 32'(td_a), 32'hA5);
    chk("lat1 fc_a", 32'(fc_a), 32'd0);
    chk("lat1 ts_b", 32'(ts_b), 32'd1);
    chk("lat1 td_b", 32'(td_b), 32'hDE);
    wait_fd(1, 1, "single timeout");
    chk("single fc_a", 32'(fc_a), 32'd0);
    chk("single starts_a", 32'(nst_a), 32'd3);
    chk("single starts_b", 32'(nst_b), 32'd4);
    chk("single done_a", 32'(nfd_a), 32'd1);
    chk("single done_b", 32'(nfd_b), 32'd1);
    cmp("single");

    // random back-to-back pushes
    for (int i = 0; i < 3; i++) begin
      v1 = 16'($urandom);
      w  = $urandom;
      pv_a = 1'b1;
      pd_a = v1;
      pv_b = 1'b1;
      pd_b = w;
      exp_frame_a(v1);
      exp_frame_b(w);
      tick();
    end
    pv_a = 1'b0;
    pv_b = 1'b0;
    wait_fd(4, 4, "rand timeout");
    chk("rand done_a", 32'(nfd_a), 32'd4);
    cmp("rand");

    // fill while disabled, overflow on the fifth push
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v1 = 16'($urandom);
      pv_a = 1'b1;
      pd_a = v1;
      if (i < 4) exp_frame_a(v1);
      #1;
      if (i == 0) chk("ovf idle ov_a", 32'(ov_a), 32'd0);
      if (i == 4) begin
        chk("ovf ov_a", 32'(ov_a), 32'd1);
        chk("ovf pr_a", 32'(pr_a), 32'd0);
      end
      tick();
      if (i == 3) begin
        chk("full pr_a", 32'(pr_a), 32'd0);
        chk("full fc_a", 32'(fc_a), 32'd4);
      end
    end
    pv_a = 1'b0;
    #1;
    chk("ovf clear ov_a", 32'(ov_a), 32'd0);
    chk("ovf fc_a", 32'(fc_a), 32'd4);
    repeat (5) tick();
    chk("hold fc_a", 32'(fc_a), 32'd4);
    chk("hold ts_a", 32'(ts_a), 32'd0);
    ena = 1'b1;
    wait_fd(8, 4, "ovf timeout");
    chk("ovf fc_a end", 32'(fc_a), 32'd0);
    cmp("ovf");

    // abort during byte 1 of the first of two frames
    ena = 1'b0;
    v1 = 16'($urandom);
    v2 = 16'($urandom);
    pv_a = 1'b1;
    pd_a = v1;
    tick();
    pd_a = v2;
    tick();
    pv_a = 1'b0;
    exp_a.push_back(8'hA5);
    exp_a.push_back(8'(v1));
    exp_frame_a(v2);
    base = cap_a.size();
    fdb  = nfd_a;
    ena  = 1'b1;
    n    = 0;
    while (cap_a.size() < base + 2 && n < 500) begin
      tick();
      n++;
    end
    chk("abort reach", 32'(n < 500), 32'd1);
    ena = 1'b0;
    tick();
    chk("abort ts_a", 32'(ts_a), 32'd0);
    chk("abort fc_a", 32'(fc_a), 32'd1);
    n = 0;
    while (tb_a && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("abort no done", 32'(nfd_a), 32'(fdb));
    ena = 1'b1;
    wait_fd(fdb + 1, nfd_b, "abort timeout");
    repeat (40) tick();
    chk("abort one done", 32'(nfd_a), 32'(fdb + 1));
    chk("abort fc_a end", 32'(fc_a), 32'd0);
    cmp("abort");

    // push on the pop cycle with one entry queued
    ena = 1'b0;
    v1 = 16'($urandom);
    v2 = 16'($urandom);
    pv_a = 1'b1;
    pd_a = v1;
    tick();
    chk("simul pre fc_a", 32'(fc_a), 32'd1);
    ena  = 1'b1;
    pd_a = v2;
    tick();
    pv_a = 1'b0;
    chk("simul fc_a", 32'(fc_a), 32'd1);
    chk("simul ts_a", 32'(ts_a), 32'd1);
    exp_frame_a(v1);
    exp_frame_a(v2);
    fdb = nfd_a;
    wait_fd(fdb + 2, nfd_b, "simul timeout");
    cmp("simul");

    // asynchronous reset in the middle of a frame
    ena = 1'b0;
    pv_a = 1'b1;
    pd_a = 16'($urandom);
    tick();
    pd_a = 16'($urandom);
    tick();
    pv_a = 1'b0;
    ena = 1'b1;
    n = 0;
    while (!ts_a && n < 100) begin
      tick();
      n++;
    end
    chk("arst pre ts_a", 32'(ts_a), 32'd1);
    chk("arst pre fc_a", 32'(fc_a), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst ts_a", 32'(ts_a), 32'd0);
    chk("arst fc_a", 32'(fc_a), 32'd0);
    chk("arst pr_a", 32'(pr_a), 32'd1);
    chk("arst td_a", 32'(td_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
